// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX/MEM -> data-memory req/ack -> MEM/WB.
// Optional LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rs2,
    input  logic [4:0]  mem_rd_ind,
    input  logic        mem_rd_indzero,
    input  logic [11:0] mem_opcode,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd_ind,
    output logic        wb_rd_indzero,
    output logic        wb_regwrite,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        wb_valid
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [4:0]  wb_rd_ind_q, wb_rd_ind_d;
    logic        wb_rd_indzero_q, wb_rd_indzero_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_valid_q, wb_valid_d;
    logic        mis_q, mis_d;
    logic        misalign_q, misalign_d;

    logic        access;
    logic        is_store;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        sz_byte;
    logic        sz_half;
    logic        sz_word;
    logic        bad_align;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] ld_fmt;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign access   = mem_memread | mem_memwrite;
    assign is_store = mem_memwrite;
    assign is_load  = mem_memread & ~mem_memwrite;
    assign f3       = mem_opcode[9:7];
    assign off      = mem_alu_out[1:0];

    // Stores decode only 000/001 as narrow; loads also accept 100/101.
    always_comb begin
        if (is_store) begin
            sz_byte = (f3 == 3'b000);
            sz_half = (f3 == 3'b001);
        end else begin
            sz_byte = (f3[1:0] == 2'b00);
            sz_half = (f3[1:0] == 2'b01);
        end
        sz_word   = ~sz_byte & ~sz_half;
        bad_align = (sz_half & off[0]) | (sz_word & (off != 2'b00));
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = mem_rs2;
        if (sz_byte) begin
            be_calc    = 4'b0001 << off;
            wdata_calc = {4{mem_rs2[7:0]}};
        end else if (sz_half) begin
            be_calc    = 4'b0011 << {off[1], 1'b0};
            wdata_calc = {2{mem_rs2[15:0]}};
        end
    end

    always_comb begin
        ld_b = dm_rdata[{off, 3'b000} +: 8];
        ld_h = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        unique case (f3)
            3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_fmt = {24'h0, ld_b};
            3'b101:  ld_fmt = {16'h0, ld_h};
            default: ld_fmt = dm_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        dm_req_d        = dm_req_q;
        dm_we_d         = dm_we_q;
        dm_addr_d       = dm_addr_q;
        dm_wdata_d      = dm_wdata_q;
        dm_be_d         = dm_be_q;
        ld_data_d       = ld_data_q;
        wb_result_d     = wb_result_q;
        wb_rd_ind_d     = wb_rd_ind_q;
        wb_rd_indzero_d = wb_rd_indzero_q;
        wb_regwrite_d   = 1'b0;
        wb_valid_d      = 1'b0;
        mis_d           = mis_q;
        misalign_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!access) begin
                    wb_result_d     = mem_alu_out;
                    wb_rd_ind_d     = mem_rd_ind;
                    wb_rd_indzero_d = mem_rd_indzero;
                    wb_regwrite_d   = mem_regwrite;
                    wb_valid_d      = 1'b1;
                end else begin
`ifdef LSU_MISALIGN_CHECK_EN
                    if (bad_align) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mis_d      = 1'b0;
                        state_d    = REQ;
                        dm_req_d   = 1'b1;
                        dm_we_d    = is_store;
                        dm_addr_d  = {mem_alu_out[31:2], 2'b00};
                        dm_wdata_d = wdata_calc;
                        dm_be_d    = be_calc;
                    end
`else
                    mis_d      = 1'b0;
                    state_d    = REQ;
                    dm_req_d   = 1'b1;
                    dm_we_d    = is_store;
                    dm_addr_d  = {mem_alu_out[31:2], 2'b00};
                    dm_wdata_d = wdata_calc;
                    dm_be_d    = be_calc;
`endif
                end
            end
            REQ: begin
                if (dm_ack) begin
                    dm_req_d  = 1'b0;
                    ld_data_d = ld_fmt;
                    state_d   = DONE;
                end
            end
            DONE: begin
                wb_result_d     = is_load ? ld_data_q : mem_alu_out;
                wb_rd_ind_d     = mem_rd_ind;
                wb_rd_indzero_d = mem_rd_indzero;
                wb_regwrite_d   = mem_regwrite & ~mis_q;
                wb_valid_d      = 1'b1;
                misalign_d      = mis_q;
                mis_d           = 1'b0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            dm_req_q        <= 1'b0;
            dm_we_q         <= 1'b0;
            dm_addr_q       <= 32'h0;
            dm_wdata_q      <= 32'h0;
            dm_be_q         <= 4'h0;
            ld_data_q       <= 32'h0;
            wb_result_q     <= 32'h0;
            wb_rd_ind_q     <= 5'h0;
            wb_rd_indzero_q <= 1'b0;
            wb_regwrite_q   <= 1'b0;
            wb_valid_q      <= 1'b0;
            mis_q           <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dm_req_q        <= dm_req_d;
            dm_we_q         <= dm_we_d;
            dm_addr_q       <= dm_addr_d;
            dm_wdata_q      <= dm_wdata_d;
            dm_be_q         <= dm_be_d;
            ld_data_q       <= ld_data_d;
            wb_result_q     <= wb_result_d;
            wb_rd_ind_q     <= wb_rd_ind_d;
            wb_rd_indzero_q <= wb_rd_indzero_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_valid_q      <= wb_valid_d;
            mis_q           <= mis_d;
            misalign_q      <= misalign_d;
        end
    end

    assign stall         = access & (state_q != DONE);
    assign dm_req        = dm_req_q;
    assign dm_we         = dm_we_q;
    assign dm_addr       = dm_addr_q;
    assign dm_wdata      = dm_wdata_q;
    assign dm_be         = dm_be_q;
    assign wb_result     = wb_result_q;
    assign wb_rd_ind     = wb_rd_ind_q;
    assign wb_rd_indzero = wb_rd_indzero_q;
    assign wb_regwrite   = wb_regwrite_q;
    assign wb_valid      = wb_valid_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign      = misalign_q;
`else
    logic unused_mis;
    assign unused_mis = misalign_q ^ bad_align;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, loads, stores, reset.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_rs2;
    logic [4:0]  mem_rd_ind;
    logic        mem_rd_indzero;
    logic [11:0] mem_opcode;
    logic        mem_regwrite;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd_ind;
    logic        wb_rd_indzero;
    logic        wb_regwrite;
    logic        wb_valid;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    int          cyc;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .mem_alu_out(mem_alu_out), .mem_rs2(mem_rs2),
        .mem_rd_ind(mem_rd_ind), .mem_rd_indzero(mem_rd_indzero),
        .mem_opcode(mem_opcode), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_result(wb_result), .wb_rd_ind(wb_rd_ind),
        .wb_rd_indzero(wb_rd_indzero), .wb_regwrite(wb_regwrite),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .wb_valid(wb_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd, input logic [2:0] f3,
                          input logic rdm, input logic wrm,
                          input logic rw);
        mem_alu_out    = a;
        mem_rs2        = d;
        mem_rd_ind     = rd;
        mem_rd_indzero = (rd == 5'd0);
        mem_opcode     = {2'b00, f3, wrm ? 7'h23 : (rdm ? 7'h03 : 7'h33)};
        mem_memread    = rdm;
        mem_memwrite   = wrm;
        mem_regwrite   = rw;
        #1;
    endtask

    // Runs one access from its IDLE cycle; returns stall-high cycle count.
    task automatic run_access(input int waits, input logic [31:0] rd_data,
                              output int cycles);
        int w;
        bit done;
        w = 0;
        done = 0;
        cycles = 1;
        chk("stall_idle", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            dm_ack = 1'b0;
            if (!stall) begin
                done = 1;
            end else begin
                cycles++;
                if (dm_req) begin
                    if (i == 0) begin
                        s_we = dm_we;
                        s_addr = dm_addr;
                        s_wdata = dm_wdata;
                        s_be = dm_be;
                    end
                    if (w == waits) begin
                        dm_ack = 1'b1;
                        dm_rdata = rd_data;
                    end
                    w++;
                end
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        chk("done_req_low", {31'b0, dm_req}, 32'd0);
        chk("done_bubble", {31'b0, wb_valid}, 32'd0);
    endtask

    task automatic idle_inputs();
        set_op(32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        s_we = 1'b0;
        s_addr = 32'h0;
        s_wdata = 32'h0;
        s_be = 4'h0;
        idle_inputs();
        tick();
        tick();
        chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_result", wb_result, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        // ADD pass-through, stray ack ignored
        set_op(32'h0000_1234, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1);
        dm_ack = 1'b1;
        chk("add_stall", {31'b0, stall}, 32'd0);
        tick();
        dm_ack = 1'b0;
        chk("add_result", wb_result, 32'h0000_1234);
        chk("add_rd", {27'b0, wb_rd_ind}, 32'd5);
        chk("add_valid", {31'b0, wb_valid}, 32'd1);
        chk("add_regwrite", {31'b0, wb_regwrite}, 32'd1);
        chk("add_no_req", {31'b0, dm_req}, 32'd0);

        // LB 0x103, two wait cycles
        set_op(32'h0000_0103, 32'h0, 5'd7, 3'b000, 1'b1, 1'b0, 1'b1);
        run_access(2, 32'h8000_0000, cyc);
        chk("lb_cycles", cyc, 32'd4);
        chk("lb_addr", s_addr, 32'h0000_0100);
        chk("lb_we", {31'b0, s_we}, 32'd0);
        tick();
        idle_inputs();
        chk("lb_result", wb_result, 32'hFFFF_FF80);
        chk("lb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_rd", {27'b0, wb_rd_ind}, 32'd7);

        // LHU 0x202, immediate ack
        set_op(32'h0000_0202, 32'h0, 5'd9, 3'b101, 1'b1, 1'b0, 1'b1);
        run_access(0, 32'hBEEF_0000, cyc);
        chk("lhu_cycles", cyc, 32'd2);
        tick();
        idle_inputs();
        chk("lhu_result", wb_result, 32'h0000_BEEF);

        // LH 0x200 sign-extends low half
        set_op(32'h0000_0200, 32'h0, 5'd10, 3'b001, 1'b1, 1'b0, 1'b1);
        run_access(1, 32'h0000_8001, cyc);
        chk("lh_cycles", cyc, 32'd3);
        tick();
        idle_inputs();
        chk("lh_result", wb_result, 32'hFFFF_8001);

        // LW 0x10
        set_op(32'h0000_0010, 32'h0, 5'd11, 3'b010, 1'b1, 1'b0, 1'b1);
        run_access(0, 32'h1234_5678, cyc);
        tick();
        idle_inputs();
        chk("lw_result", wb_result, 32'h1234_5678);

        // SB 0x41
        set_op(32'h0000_0041, 32'h0000_00AB, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        run_access(0, 32'h0, cyc);
        chk("sb_we", {31'b0, s_we}, 32'd1);
        chk("sb_be", {28'b0, s_be}, 32'b0010);
        chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
        chk("sb_addr", s_addr, 32'h0000_0040);
        tick();
        idle_inputs();
        chk("sb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sb_regwrite", {31'b0, wb_regwrite}, 32'd0);

        // SH 0x56
        set_op(32'h0000_0056, 32'h1234_CAFE, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
        run_access(1, 32'h0, cyc);
        chk("sh_be", {28'b0, s_be}, 32'b1100);
        chk("sh_wdata", s_wdata, 32'hCAFE_CAFE);
        chk("sh_addr", s_addr, 32'h0000_0054);
        tick();
        idle_inputs();

        // SW 0x8
        set_op(32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0);
        run_access(0, 32'h0, cyc);
        chk("sw_be", {28'b0, s_be}, 32'b1111);
        chk("sw_wdata", s_wdata, 32'hDEAD_BEEF);
        tick();
        idle_inputs();

`ifdef LSU_MISALIGN_CHECK_EN
        set_op(32'h0000_0006, 32'h0, 5'd12, 3'b010, 1'b1, 1'b0, 1'b1);
        chk("mis_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("mis_no_req", {31'b0, dm_req}, 32'd0);
        chk("mis_done_stall", {31'b0, stall}, 32'd0);
        tick();
        idle_inputs();
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_regwrite", {31'b0, wb_regwrite}, 32'd0);
        chk("mis_valid", {31'b0, wb_valid}, 32'd1);
        tick();
        chk("mis_clear", {31'b0, misalign}, 32'd0);
`endif

        // Reset while request outstanding
        set_op(32'h0000_0020, 32'h0, 5'd3, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        chk("pre_rst_req", {31'b0, dm_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, dm_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, wb_valid}, 32'd0);
        chk("mid_rst_result", wb_result, 32'h0);
        chk("mid_rst_addr", dm_addr, 32'h0);
        idle_inputs();
        tick();
        rst = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        tick();
        dm_ack = 1'b0;
        chk("post_rst_req", {31'b0, dm_req}, 32'd0);
        chk("post_rst_result", wb_result, 32'h0);
        chk("post_rst_stall", {31'b0, stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
